// File: rtl/step_divider.sv
// step_divider: sequential unsigned fixed-point divider, the responder on the
// motion-core divider interface.
//   quotinent = floor((divident << FRAC_BITS) / divisor)
// Restoring algorithm. It retires one quotient bit per clock by default, or
// two bits per clock when DIV_RADIX4_EN is defined.
//
// Optional feature macro: DIV_RADIX4_EN
//   undefined : radix-2, result WIDTH+FRAC_BITS clocks after the accepting edge
//   defined   : two chained restoring steps per clock, half the latency.
//               WIDTH+FRAC_BITS must be even.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   divident      unsigned numerator, sampled when start_divide=1
//   divisor       unsigned denominator, sampled when start_divide=1
//   start_divide  request pulse; accepted in any state, aborts a running divide
//   quotinent     result; it changes only on a completion edge
//   divide_done   level, high while quotinent belongs to the last accepted request
//   busy          high while an iteration is in progress
module step_divider #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           divident,
    input  logic [WIDTH-1:0]           divisor,
    input  logic                       start_divide,
    output logic [WIDTH+FRAC_BITS-1:0] quotinent,
    output logic                       divide_done,
    output logic                       busy
);

    localparam int QW = WIDTH + FRAC_BITS;
`ifdef DIV_RADIX4_EN
    localparam int BITS_PER_CLK = 2;
`else
    localparam int BITS_PER_CLK = 1;
`endif
    localparam int STEPS = QW / BITS_PER_CLK;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

`ifdef DIV_RADIX4_EN
    generate
        if ((QW % 2) != 0) begin : g_odd_width
            $error("step_divider: WIDTH+FRAC_BITS must be even with DIV_RADIX4_EN");
        end
    endgenerate
`endif

    logic [0:0]       state;
    logic [WIDTH-1:0] div_r;
    logic [QW-1:0]    num_sr;
    logic [QW-1:0]    q_sr;
    // The partial remainder is always below the divisor, so WIDTH bits are
    // enough to store it. The extra compare bit lives only in t below.
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] rem_nxt;
    logic [QW-1:0]    num_nxt;
    logic [QW-1:0]    q_nxt;
    logic [WIDTH:0]   t;

    // One or two restoring steps chained combinationally.
    always_comb begin
        rem_nxt = rem;
        num_nxt = num_sr;
        q_nxt   = q_sr;
        t       = '0;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            t       = {rem_nxt, num_nxt[QW-1]};
            num_nxt = {num_nxt[QW-2:0], 1'b0};
            if (t >= {1'b0, div_r}) begin
                // The true difference is below the divisor, so a WIDTH-bit
                // subtraction that wraps modulo 2^WIDTH gives the exact value.
                rem_nxt = t[WIDTH-1:0] - div_r;
                q_nxt   = {q_nxt[QW-2:0], 1'b1};
            end else begin
                rem_nxt = t[WIDTH-1:0];
                q_nxt   = {q_nxt[QW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_r       <= '0;
            num_sr      <= '0;
            q_sr        <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotinent   <= '0;
            divide_done <= 1'b0;
            busy        <= 1'b0;
        end else if (start_divide) begin
            // A start is accepted in any state. It also wins over a completion
            // on the same edge, so quotinent keeps its previous value.
            state       <= RUN;
            div_r       <= divisor;
            num_sr      <= {divident, {FRAC_BITS{1'b0}}};
            q_sr        <= '0;
            rem         <= '0;
            cnt         <= CW'(STEPS);
            divide_done <= 1'b0;
            busy        <= 1'b1;
        end else if (state == RUN) begin
            num_sr <= num_nxt;
            q_sr   <= q_nxt;
            rem    <= rem_nxt;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                quotinent   <= q_nxt;
                divide_done <= 1'b1;
                busy        <= 1'b0;
                state       <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_step_divider.sv
module tb_step_divider;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 64;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] divident;
    logic [31:0] divisor;
    logic        start_divide;
    logic [63:0] quotinent;
    logic        divide_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    step_divider #(.WIDTH(32), .FRAC_BITS(32)) dut (
        .clk(clk), .reset(reset), .divident(divident), .divisor(divisor),
        .start_divide(start_divide), .quotinent(quotinent),
        .divide_done(divide_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [63:0] exp;
    } vec_t;

    // Reference: plain 64-bit arithmetic. A zero divisor yields all ones.
    function automatic logic [63:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] n;
        n = {a, 32'h0};
        if (b == 32'h0) return 64'hFFFF_FFFF_FFFF_FFFF;
        return n / {32'h0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // One rising edge; outputs are sampled and inputs changed 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        divident     = a;
        divisor      = b;
        start_divide = 1'b1;
        tick();
        start_divide = 1'b0;
    endtask

    // Counts edges after the accepting edge until divide_done rises, with a bound.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!divide_done && n < LAT + 20);
    endtask

    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        int n;
        start(a, b);
        chk({name, " done_low"}, {63'h0, divide_done}, 64'h0);
        chk({name, " busy"}, {63'h0, busy}, 64'h1);
        wait_done(n);
        chk({name, " latency"}, 64'(n), 64'(LAT));
        chk({name, " quot"}, quotinent, exp);
        chk({name, " busy_end"}, {63'h0, busy}, 64'h0);
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        bit   ok;
        logic [63:0] prev;

        vecs[0] = '{32'd10,        32'd4, 64'h0000_0002_8000_0000};
        vecs[1] = '{32'd1,         32'd3, 64'h0000_0000_5555_5555};
        vecs[2] = '{32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_0000_0000};
        vecs[3] = '{32'h1234_5678, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{32'd5,         32'd5, 64'h0000_0001_0000_0000};
        vecs[5] = '{32'd0,         32'd7, 64'h0};

        reset = 1'b1; start_divide = 1'b0; divident = '0; divisor = '0;
        tick(); tick();
        chk("rst quot", quotinent, 64'h0);
        chk("rst done", {63'h0, divide_done}, 64'h0);
        chk("rst busy", {63'h0, busy}, 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_one($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].exp);

        // The result holds through 100 idle cycles.
        run_one("hold", 32'd1, 32'd3, 64'h0000_0000_5555_5555);
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!divide_done || quotinent !== 64'h0000_0000_5555_5555) ok = 1'b0;
        end
        chk("hold idle", {63'h0, ok}, 64'h1);

        // A restart aborts the first request: exactly one done, for the second.
        start(32'd7, 32'd2);
        ok = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (divide_done) ok = 1'b0;
        end
        chk("abort no_done", {63'h0, ok}, 64'h1);
        chk("abort old_quot", quotinent, 64'h0000_0000_5555_5555);
        run_one("restart", 32'd3, 32'd4, 64'h0000_0000_C000_0000);

        // A start on the completion edge wins, and quotinent keeps its old value.
        prev = quotinent;
        start(32'd9, 32'd2);
        for (int i = 0; i < LAT - 1; i++) tick();
        chk("coll pre_done", {63'h0, divide_done}, 64'h0);
        start(32'd1, 32'd2);
        chk("coll done_low", {63'h0, divide_done}, 64'h0);
        chk("coll quot_kept", quotinent, prev);
        wait_done(n);
        chk("coll latency", 64'(n), 64'(LAT));
        chk("coll quot", quotinent, 64'h0000_0000_8000_0000);

        // Reset in the middle of a division.
        start(32'd100, 32'd7);
        for (int i = 0; i < 29; i++) tick();
        reset = 1'b1;
        tick();
        chk("midrst quot", quotinent, 64'h0);
        chk("midrst done", {63'h0, divide_done}, 64'h0);
        chk("midrst busy", {63'h0, busy}, 64'h0);
        reset = 1'b0;
        tick();
        run_one("post_rst", 32'd5, 32'd5, 64'h0000_0001_0000_0000);

        // Random operands against the reference model.
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 15);
                1:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            start(a, b);
            wait_done(n);
            chk($sformatf("rnd%0d lat a=%h b=%h", i, a, b), 64'(n), 64'(LAT));
            chk($sformatf("rnd%0d quot a=%h b=%h", i, a, b), quotinent, ref_q(a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_divider.md
Name: step_divider

Overview:
- Sequential fixed-point divider. It is the responder on the motion-core divider interface (divident/divisor/start_divide -> quotinent/divide_done).
- Computes quotinent = floor((divident << FRAC_BITS) / divisor), unsigned. This gives the velocity-per-tick ratio that the trajectory block reads back.
- Restoring radix-2 algorithm, one quotient bit per clock. Shared by one requester per instance.

Parameters:
- WIDTH, 32, operand width of divident and divisor.
- FRAC_BITS, 32, fractional bits appended below divident. Quotient width is WIDTH+FRAC_BITS (64).

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- divident  input  WIDTH  unsigned numerator; sampled only when start_divide=1.
- divisor  input  WIDTH  unsigned denominator; sampled only when start_divide=1.
- start_divide  input  1  one-cycle request pulse; a level is treated as a new request every cycle.
- quotinent  output  WIDTH+FRAC_BITS  result; holds its value until the next start.
- divide_done  output  1  level; high while quotinent is valid for the last accepted request.
- busy  output  1  high while an iteration is in progress.

Behaviour:
- Reset (synchronous, wins over everything):
  - quotinent=0, divide_done=0, busy=0, state=IDLE.
  - Internal remainder, shift register and counter are cleared.
- States: IDLE, RUN.
- Accept: on any edge with start_divide=1 and reset=0, in any state:
  - latch divisor; numerator shift register N = {divident, FRAC_BITS zeros}.
  - remainder R (WIDTH+1 bits) = 0; quotient shift register Q = 0; counter = WIDTH+FRAC_BITS.
  - divide_done<=0 on this same edge; busy<=1; state<=RUN.
  - divide_done must already be low in the cycle after start_divide is sampled, because the requester polls done two cycles after it raises start.
- RUN, each edge:
  - T = {R[WIDTH-1:0], N[msb]}; N <<= 1.
  - If T >= divisor: R = T - divisor and shift 1 into Q. Otherwise R = T and shift 0 into Q.
  - counter decrements by 1.
- Completion: on the edge where counter goes 1->0:
  - quotinent<=final Q; divide_done<=1; busy<=0; state<=IDLE.
  - Latency: divide_done rises exactly WIDTH+FRAC_BITS (64) clocks after the accepting edge.
- IDLE with no start: all outputs hold, including divide_done=1 and quotinent.
- Restart mid-operation: start_divide during RUN aborts the current division with no done pulse for it. The new operands are latched and the 64-cycle count starts again from the new accepting edge.
- start_divide on the same edge as completion: the start wins. divide_done stays 0 and quotinent keeps its old value (it is not updated).
- quotinent changes only on a completion edge. It is never partially updated while RUN is in progress.
- divisor=0: no special case. T >= 0 always holds, so quotinent = all ones (0xFFFF_FFFF_FFFF_FFFF) with normal latency.
- Width: R needs WIDTH+1 bits for the compare. A WIDTH+FRAC_BITS quotient cannot overflow for any WIDTH-bit divisor >= 1.
- Remainder is internal and never exported.

Optional Feature:
- Macro: DIV_RADIX4_EN.
- Defined:
  - Two restoring steps are chained combinationally per clock, retiring 2 quotient bits per edge.
  - counter is loaded with (WIDTH+FRAC_BITS)/2; latency is 32 clocks.
  - FRAC_BITS+WIDTH must be even; elaboration fails otherwise.
  - Results, handshake and abort rules are identical to radix-2.
- Undefined: radix-2 as specified above, latency 64.

Test Plan:
- Reset, then divident=10, divisor=4, one start pulse -> divide_done low on the next cycle, busy high. divide_done rises 64 clocks after the start edge with quotinent=0x0000_0002_8000_0000.
- divident=1, divisor=3 -> quotinent=0x0000_0000_5555_5555. Result holds and divide_done stays high for 100 idle cycles.
- divident=0xFFFF_FFFF, divisor=1 -> quotinent=0xFFFF_FFFF_0000_0000. Then divisor=0 with any divident -> quotinent=0xFFFF_FFFF_FFFF_FFFF after 64 clocks.
- Start 7/2, then 20 clocks later start 3/4 -> exactly one done, 64 clocks after the second start, quotinent=0x0000_0000_C000_0000. No done is seen for the first request.
- Reset asserted 30 clocks into a division -> quotinent=0, divide_done=0, busy=0 on the next cycle. A fresh 5/5 then yields 0x0000_0001_0000_0000.
- With DIV_RADIX4_EN, repeat the first three cases -> identical quotients, divide_done at 32 clocks. Random-operand run compared against a software model, 10k vectors.
